// File: rtl/filter_luma_8tap.sv
// Eight-tap luma interpolation filter shared by FLUX interleaved data fluxes.
// Three-stage pipeline (operands, products, shifted sum) that freezes as a whole on output backpressure.
module filter_luma_8tap #(
  parameter int FLUX        = 2,
  parameter int PIX_WIDTH   = 8,
  parameter int COEFF_WIDTH = 9,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 0,
`ifdef MONO
  localparam int TAG_WIDTH  = 0
`else
  localparam int TAG_WIDTH  = $clog2(FLUX)
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic [FLUX-1:0]                  read_port_p0_empty,
  output logic [FLUX-1:0]                  read_port_p0_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p0_dout,
  input  logic [FLUX-1:0]                  read_port_p1_empty,
  output logic [FLUX-1:0]                  read_port_p1_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p1_dout,
  input  logic [FLUX-1:0]                  read_port_p2_empty,
  output logic [FLUX-1:0]                  read_port_p2_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p2_dout,
  input  logic [FLUX-1:0]                  read_port_p3_empty,
  output logic [FLUX-1:0]                  read_port_p3_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p3_dout,
  input  logic [FLUX-1:0]                  read_port_p4_empty,
  output logic [FLUX-1:0]                  read_port_p4_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p4_dout,
  input  logic [FLUX-1:0]                  read_port_p5_empty,
  output logic [FLUX-1:0]                  read_port_p5_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p5_dout,
  input  logic [FLUX-1:0]                  read_port_p6_empty,
  output logic [FLUX-1:0]                  read_port_p6_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p6_dout,
  input  logic [FLUX-1:0]                  read_port_p7_empty,
  output logic [FLUX-1:0]                  read_port_p7_read,
  input  logic [TAG_WIDTH+PIX_WIDTH-1:0]   read_port_p7_dout,

  input  logic [FLUX-1:0]                  read_port_c0_empty,
  output logic [FLUX-1:0]                  read_port_c0_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c0_dout,
  input  logic [FLUX-1:0]                  read_port_c1_empty,
  output logic [FLUX-1:0]                  read_port_c1_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c1_dout,
  input  logic [FLUX-1:0]                  read_port_c2_empty,
  output logic [FLUX-1:0]                  read_port_c2_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c2_dout,
  input  logic [FLUX-1:0]                  read_port_c3_empty,
  output logic [FLUX-1:0]                  read_port_c3_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c3_dout,
  input  logic [FLUX-1:0]                  read_port_c4_empty,
  output logic [FLUX-1:0]                  read_port_c4_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c4_dout,
  input  logic [FLUX-1:0]                  read_port_c5_empty,
  output logic [FLUX-1:0]                  read_port_c5_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c5_dout,
  input  logic [FLUX-1:0]                  read_port_c6_empty,
  output logic [FLUX-1:0]                  read_port_c6_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c6_dout,
  input  logic [FLUX-1:0]                  read_port_c7_empty,
  output logic [FLUX-1:0]                  read_port_c7_read,
  input  logic [TAG_WIDTH+COEFF_WIDTH-1:0] read_port_c7_dout,

  input  logic [FLUX-1:0]                  write_port_out_full,
  output logic                             write_port_out_write,
  output logic [TAG_WIDTH+OUT_WIDTH-1:0]   write_port_out_din
);

  localparam int TW         = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
  localparam int PROD_WIDTH = PIX_WIDTH + COEFF_WIDTH;
  localparam int SUM_WIDTH  = PROD_WIDTH + 3;

  logic [PIX_WIDTH-1:0]          pix_in [8];
  logic [COEFF_WIDTH-1:0]        coeff_in [8];
  logic [FLUX-1:0]               any_empty;
  logic [FLUX-1:0]               eligible;
  logic                          sel_found;
  logic [TW-1:0]                 sel_idx;
  logic                          advance;
  logic                          issue;
  logic                          full_at_tag3;
  logic [FLUX-1:0]               read_vec;
  logic                          unused_tag_bits;

  logic                          v1, v2, v3;
  logic [TW-1:0]                 tag1, tag2, tag3;
  logic [PIX_WIDTH-1:0]          p1 [8];
  logic [COEFF_WIDTH-1:0]        c1 [8];
  logic signed [PROD_WIDTH-1:0]  prod1 [8];
  logic signed [PROD_WIDTH-1:0]  prod2 [8];
  logic signed [SUM_WIDTH-1:0]   sum2;
  logic signed [SUM_WIDTH-1:0]   shifted2;
  logic [OUT_WIDTH-1:0]          y2, y3;

  // Tag bits of the incoming words are never compared; only the data fields are kept.
  assign pix_in[0]   = read_port_p0_dout[PIX_WIDTH-1:0];
  assign pix_in[1]   = read_port_p1_dout[PIX_WIDTH-1:0];
  assign pix_in[2]   = read_port_p2_dout[PIX_WIDTH-1:0];
  assign pix_in[3]   = read_port_p3_dout[PIX_WIDTH-1:0];
  assign pix_in[4]   = read_port_p4_dout[PIX_WIDTH-1:0];
  assign pix_in[5]   = read_port_p5_dout[PIX_WIDTH-1:0];
  assign pix_in[6]   = read_port_p6_dout[PIX_WIDTH-1:0];
  assign pix_in[7]   = read_port_p7_dout[PIX_WIDTH-1:0];
  assign coeff_in[0] = read_port_c0_dout[COEFF_WIDTH-1:0];
  assign coeff_in[1] = read_port_c1_dout[COEFF_WIDTH-1:0];
  assign coeff_in[2] = read_port_c2_dout[COEFF_WIDTH-1:0];
  assign coeff_in[3] = read_port_c3_dout[COEFF_WIDTH-1:0];
  assign coeff_in[4] = read_port_c4_dout[COEFF_WIDTH-1:0];
  assign coeff_in[5] = read_port_c5_dout[COEFF_WIDTH-1:0];
  assign coeff_in[6] = read_port_c6_dout[COEFF_WIDTH-1:0];
  assign coeff_in[7] = read_port_c7_dout[COEFF_WIDTH-1:0];

  assign unused_tag_bits = ^{read_port_p0_dout, read_port_p1_dout, read_port_p2_dout,
                             read_port_p3_dout, read_port_p4_dout, read_port_p5_dout,
                             read_port_p6_dout, read_port_p7_dout, read_port_c0_dout,
                             read_port_c1_dout, read_port_c2_dout, read_port_c3_dout,
                             read_port_c4_dout, read_port_c5_dout, read_port_c6_dout,
                             read_port_c7_dout};

  assign any_empty = read_port_p0_empty | read_port_p1_empty | read_port_p2_empty |
                     read_port_p3_empty | read_port_p4_empty | read_port_p5_empty |
                     read_port_p6_empty | read_port_p7_empty | read_port_c0_empty |
                     read_port_c1_empty | read_port_c2_empty | read_port_c3_empty |
                     read_port_c4_empty | read_port_c5_empty | read_port_c6_empty |
                     read_port_c7_empty;
  assign eligible  = ~any_empty;

  // Scanning downward lets the lowest eligible flux win the fixed priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = TW'(i);
      end
    end
  end

  assign full_at_tag3 = write_port_out_full[tag3];
  assign advance      = !v3 || !full_at_tag3;
  assign issue        = rst_n && advance && sel_found;

  always_comb begin
    read_vec = '0;
    if (issue) read_vec[sel_idx] = 1'b1;
  end

  assign read_port_p0_read = read_vec;
  assign read_port_p1_read = read_vec;
  assign read_port_p2_read = read_vec;
  assign read_port_p3_read = read_vec;
  assign read_port_p4_read = read_vec;
  assign read_port_p5_read = read_vec;
  assign read_port_p6_read = read_vec;
  assign read_port_p7_read = read_vec;
  assign read_port_c0_read = read_vec;
  assign read_port_c1_read = read_vec;
  assign read_port_c2_read = read_vec;
  assign read_port_c3_read = read_vec;
  assign read_port_c4_read = read_vec;
  assign read_port_c5_read = read_vec;
  assign read_port_c6_read = read_vec;
  assign read_port_c7_read = read_vec;

  // Pixels are unsigned, so they get a zero sign bit before the signed multiply.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      prod1[k] = $signed(PROD_WIDTH'({1'b0, p1[k]})) *
                 $signed(PROD_WIDTH'($signed(c1[k])));
    end
  end

  always_comb begin
    sum2 = '0;
    for (int k = 0; k < 8; k++) begin
      sum2 = sum2 + SUM_WIDTH'(prod2[k]);
    end
    shifted2 = sum2 >>> SHIFT;
    y2       = OUT_WIDTH'(shifted2);
  end

  // All three stages move in lockstep; a full head sample freezes everything behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      y3   <= '0;
      for (int k = 0; k < 8; k++) begin
        p1[k]    <= '0;
        c1[k]    <= '0;
        prod2[k] <= '0;
      end
    end else if (advance) begin
      v1 <= issue;
      if (issue) begin
        tag1 <= sel_idx;
        for (int k = 0; k < 8; k++) begin
          p1[k] <= pix_in[k];
          c1[k] <= coeff_in[k];
        end
      end
      v2   <= v1;
      tag2 <= tag1;
      for (int k = 0; k < 8; k++) begin
        prod2[k] <= prod1[k];
      end
      v3   <= v2;
      tag3 <= tag2;
      y3   <= y2;
    end
  end

  assign write_port_out_write = rst_n && v3 && !full_at_tag3;

  generate
    if (TAG_WIDTH > 0) begin : g_tagged
      assign write_port_out_din = {tag3[TAG_WIDTH-1:0], y3};
    end else begin : g_mono
      assign write_port_out_din = y3;
    end
  endgenerate

endmodule

// File: tb/tb_filter_luma_8tap.sv
// Directed bench for filter_luma_8tap: table of hand-computed filter vectors fed through two
// modelled source FIFOs, with a per-flux scoreboard and sequences for stall, priority and reset.
module tb_filter_luma_8tap;

  typedef struct packed {
    logic [7:0][7:0] p;
    logic [7:0][8:0] c;
    logic [15:0]     e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  emp;
  logic [1:0]  emp_c5;
  logic        xe;
  logic [1:0]  rd_p [8];
  logic [1:0]  rd_c [8];
  logic [8:0]  pdata [8];
  logic [9:0]  cdata [8];
  logic [1:0]  full;
  logic        wr;
  logic [16:0] din;

  vec_t vecs [8];
  vec_t q0 [$];
  vec_t q1 [$];
  logic [15:0] e0 [$];
  logic [15:0] e1 [$];
  vec_t h0, h1;
  logic sel_bus;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int rd0 = 0;
  int rd1 = 0;
  int wr_cnt = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;

  int tab_p [8][8] = '{
    '{0, 0, 0, 100, 0, 0, 0, 0},
    '{0, 255, 0, 255, 0, 255, 0, 255},
    '{255, 0, 255, 0, 0, 255, 0, 0},
    '{255, 255, 255, 255, 255, 255, 255, 255},
    '{255, 255, 255, 255, 255, 255, 255, 255},
    '{1, 2, 3, 4, 5, 6, 7, 8},
    '{10, 20, 30, 40, 50, 60, 70, 80},
    '{0, 0, 0, 0, 0, 0, 0, 0}};
  int tab_c [8][8] = '{
    '{0, 0, 0, 64, 0, 0, 0, 0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{-1, 4, -10, 58, 17, -5, 1, 0},
    '{-256, -256, -256, -256, -256, -256, -256, -256},
    '{255, 255, 255, 255, 255, 255, 255, 255},
    '{1, 1, 1, 1, 1, 1, 1, 1},
    '{1, -1, 2, -2, 3, -3, 4, -4},
    '{-256, -256, -256, -256, -256, -256, -256, -256}};
  logic [15:0] tab_e [8] = '{16'h1900, 16'h1FE0, 16'hF010, 16'h0800,
                             16'hF008, 16'h0024, 16'hFF9C, 16'h0000};

  always #5 clk = ~clk;

  assign emp_c5 = emp | {1'b0, xe};

  // Source FIFOs are show-ahead: the data bus carries the head of whichever flux is being read.
  always_comb begin
    sel_bus = rd_p[0][1] & ~rd_p[0][0];
    for (int k = 0; k < 8; k++) begin
      pdata[k] = {sel_bus, sel_bus ? h1.p[k] : h0.p[k]};
      cdata[k] = {sel_bus, sel_bus ? h1.c[k] : h0.c[k]};
    end
  end

  filter_luma_8tap dut (
    .clk(clk), .rst_n(rst_n),
    .read_port_p0_empty(emp), .read_port_p0_read(rd_p[0]), .read_port_p0_dout(pdata[0]),
    .read_port_p1_empty(emp), .read_port_p1_read(rd_p[1]), .read_port_p1_dout(pdata[1]),
    .read_port_p2_empty(emp), .read_port_p2_read(rd_p[2]), .read_port_p2_dout(pdata[2]),
    .read_port_p3_empty(emp), .read_port_p3_read(rd_p[3]), .read_port_p3_dout(pdata[3]),
    .read_port_p4_empty(emp), .read_port_p4_read(rd_p[4]), .read_port_p4_dout(pdata[4]),
    .read_port_p5_empty(emp), .read_port_p5_read(rd_p[5]), .read_port_p5_dout(pdata[5]),
    .read_port_p6_empty(emp), .read_port_p6_read(rd_p[6]), .read_port_p6_dout(pdata[6]),
    .read_port_p7_empty(emp), .read_port_p7_read(rd_p[7]), .read_port_p7_dout(pdata[7]),
    .read_port_c0_empty(emp), .read_port_c0_read(rd_c[0]), .read_port_c0_dout(cdata[0]),
    .read_port_c1_empty(emp), .read_port_c1_read(rd_c[1]), .read_port_c1_dout(cdata[1]),
    .read_port_c2_empty(emp), .read_port_c2_read(rd_c[2]), .read_port_c2_dout(cdata[2]),
    .read_port_c3_empty(emp), .read_port_c3_read(rd_c[3]), .read_port_c3_dout(cdata[3]),
    .read_port_c4_empty(emp), .read_port_c4_read(rd_c[4]), .read_port_c4_dout(cdata[4]),
    .read_port_c5_empty(emp_c5), .read_port_c5_read(rd_c[5]), .read_port_c5_dout(cdata[5]),
    .read_port_c6_empty(emp), .read_port_c6_read(rd_c[6]), .read_port_c6_dout(cdata[6]),
    .read_port_c7_empty(emp), .read_port_c7_read(rd_c[7]), .read_port_c7_dout(cdata[7]),
    .write_port_out_full(full), .write_port_out_write(wr), .write_port_out_din(din)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic refreshSources();
    emp = {q1.size() == 0, q0.size() == 0};
    h0  = (q0.size() > 0) ? q0[0] : '0;
    h1  = (q1.size() > 0) ? q1[0] : '0;
  endtask

  task automatic applyStimulus(input int flux, input int idx);
    if (flux == 0) q0.push_back(vecs[idx]);
    else           q1.push_back(vecs[idx]);
    refreshSources();
  endtask

  // One clock: check handshakes and outputs at the falling edge, retire read samples after the rise.
  task automatic clockCycle();
    logic r0, r1, uniform;
    vec_t v;
    @(negedge clk);
    cyc++;
    r0 = rd_p[0][0];
    r1 = rd_p[0][1];
    uniform = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (rd_p[k] !== rd_p[0] || rd_c[k] !== rd_p[0]) uniform = 1'b0;
    end
    checkOutput("read_uniform", uniform, 1);
    checkOutput("read_legal", (r0 & ((q0.size() == 0) | xe)) | (r1 & (q1.size() == 0)) |
                ((r0 | r1) & !rst_n) | (r0 & r1), 0);
    if (wr === 1'b1) begin
      checkOutput("write_legal", !rst_n || full[din[16]], 0);
      wr_cnt++;
      last_wr_cyc = cyc;
      if (din[16] == 1'b0) begin
        if (e0.size() == 0) checkOutput("spurious_out_flux0", 1, 0);
        else checkOutput("out_flux0", din[15:0], e0.pop_front());
      end else begin
        if (e1.size() == 0) checkOutput("spurious_out_flux1", 1, 0);
        else checkOutput("out_flux1", din[15:0], e1.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (r0 && q0.size() > 0) begin
      v = q0.pop_front();
      e0.push_back(v.e);
      rd0++;
      last_rd_cyc = cyc;
    end
    if (r1 && q1.size() > 0) begin
      v = q1.pop_front();
      e1.push_back(v.e);
      rd1++;
      last_rd_cyc = cyc;
    end
    refreshSources();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + e0.size() + e1.size()) > 0 && n < 40) begin
      clockCycle();
      n++;
    end
    checkOutput("drain_done", q0.size() + q1.size() + e0.size() + e1.size(), 0);
  endtask

  task automatic runSingle(input int idx);
    int w, n;
    w = wr_cnt;
    n = 0;
    applyStimulus(0, idx);
    while (wr_cnt == w && n < 10) begin
      clockCycle();
      n++;
    end
    checkOutput("vec_seen", wr_cnt - w, 1);
    checkOutput("vec_latency", last_wr_cyc - last_rd_cyc, 3);
  endtask

  initial begin
    int r0b, r1b, w;
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0b, r1b, w;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        vecs[i].p[k] = tab_p[i][k][7:0];
        vecs[i].c[k] = tab_c[i][k][8:0];
      end
      vecs[i].e = tab_e[i];
    end
    rst_n = 1'b0;
    full  = 2'b00;
    xe    = 1'b0;
    refreshSources();

    // Reset holds write and read low even with data waiting.
    clockCycle();
    applyStimulus(0, 0);
    clockCycle();
    checkOutput("reset_write", wr, 0);
    checkOutput("reset_read", rd_p[0], 0);
    checkOutput("reset_no_issue", rd0, 0);

    // First cycle out of reset issues; result lands three cycles later.
    rst_n = 1'b1;
    r0b = rd0;
    w = wr_cnt;
    clockCycle();
    checkOutput("first_issue", rd0 - r0b, 1);
    clockCycle();
    clockCycle();
    checkOutput("no_early_write", wr_cnt - w, 0);
    clockCycle();
    checkOutput("first_write", wr_cnt - w, 1);
    checkOutput("first_latency", last_wr_cyc - last_rd_cyc, 3);

    for (int i = 1; i < 8; i++) runSingle(i);

    // Output stall: three samples fill the pipe, the rest wait until full drops.
    full = 2'b01;
    for (int i = 1; i <= 5; i++) applyStimulus(0, i);
    r0b = rd0;
    w = wr_cnt;
    repeat (6) clockCycle();
    checkOutput("bp_reads", rd0 - r0b, 3);
    checkOutput("bp_writes", wr_cnt - w, 0);
    full = 2'b00;
    drain();
    checkOutput("bp_release_writes", wr_cnt - w, 5);

    // Fixed priority: flux 1 waits until flux 0 runs dry.
    for (int i = 0; i < 4; i++) applyStimulus(0, i);
    for (int i = 4; i < 7; i++) applyStimulus(1, i);
    r0b = rd0;
    r1b = rd1;
    w = wr_cnt;
    repeat (4) clockCycle();
    checkOutput("prio_f0_reads", rd0 - r0b, 4);
    checkOutput("prio_f1_held", rd1 - r1b, 0);
    clockCycle();
    checkOutput("prio_f1_first", rd1 - r1b, 1);
    drain();
    checkOutput("prio_writes", wr_cnt - w, 7);

    // A stalled flux-1 head blocks flux 0 entirely.
    full = 2'b10;
    applyStimulus(1, 2);
    repeat (4) clockCycle();
    applyStimulus(0, 3);
    r0b = rd0;
    w = wr_cnt;
    repeat (4) clockCycle();
    checkOutput("nobypass_reads", rd0 - r0b, 0);
    checkOutput("nobypass_writes", wr_cnt - w, 0);
    full = 2'b00;
    drain();
    checkOutput("nobypass_release", wr_cnt - w, 2);

    // One empty coefficient port is enough to hold the flux back.
    xe = 1'b1;
    applyStimulus(0, 4);
    r0b = rd0;
    repeat (3) clockCycle();
    checkOutput("partial_empty_hold", rd0 - r0b, 0);
    xe = 1'b0;
    clockCycle();
    checkOutput("partial_empty_go", rd0 - r0b, 1);
    drain();

    // Reset with two samples in flight discards them.
    applyStimulus(0, 1);
    applyStimulus(0, 2);
    clockCycle();
    clockCycle();
    rst_n = 1'b0;
    clockCycle();
    e0.delete();
    rst_n = 1'b1;
    w = wr_cnt;
    repeat (5) clockCycle();
    checkOutput("flush_no_output", wr_cnt - w, 0);
    runSingle(5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/filter_luma_8tap.md
FILTER_LUMA_8TAP -- requirements
Module: filter_luma_8tap

Interface
REQ-001 SHALL have parameter FLUX, default 2, number of interleaved data fluxes sharing the block.
REQ-002 SHALL have parameter PIX_WIDTH, default 8, unsigned pixel field width.
REQ-003 SHALL have parameter COEFF_WIDTH, default 9, two's-complement coefficient field width.
REQ-004 SHALL have parameter OUT_WIDTH, default 16, two's-complement result field width.
REQ-005 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the sum.
REQ-006 SHALL derive TAG_WIDTH = $clog2(FLUX), or 0 when MONO is defined; each port's data word is {tag, field}.
REQ-007 SHALL have one clock and a synchronous, active-low reset: clk input 1 rising-edge clock.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 read_port_p0..read_port_p7  read_interface.actor  TAG_WIDTH+PIX_WIDTH  pixels p0..p7.
REQ-010 read_port_c0..read_port_c7  read_interface.actor  TAG_WIDTH+COEFF_WIDTH  coefficients c0..c7 from the luma coefficient stage.
REQ-011 write_port_out  write_interface.actor  TAG_WIDTH+OUT_WIDTH  filtered sample.
REQ-012 Each read port SHALL expose per-flux empty[FLUX-1:0] and read[FLUX-1:0]; the write port SHALL expose per-flux full[FLUX-1:0], scalar write, and din.

Function
REQ-013 SHALL compute y = (sum k=0..7 of p_k * c_k) >>> SHIFT, p_k zero-extended, c_k sign-extended, products 17 bit, sum 20 bit signed, result truncated to OUT_WIDTH bits.
REQ-014 SHALL implement three pipeline registers: S1 operands+tag, S2 eight registered products+tag, S3 shifted sum+tag, each with a valid bit v1/v2/v3.
REQ-015 SHALL define advance = !v3 | (write_port_out.full[tag3]==0); all stages shift together only when advance=1, otherwise hold.
REQ-016 Flux i is eligible when empty[i]==0 on all 16 read ports; SHALL select the lowest-index eligible flux (fixed priority).
REQ-017 Issue SHALL occur when advance=1 and an eligible flux exists: read[i]=1 on all 16 read ports for the selected flux only, same cycle, combinationally; all other read bits 0.
REQ-018 On issue, S1 SHALL load the data fields (tag bits stripped) and tag i with v1=1; on advance without issue, v1 SHALL become 0.
REQ-019 write_port_out.write SHALL equal v3 & (full[tag3]==0); din = {tag3, y3}; din is don't-care when write=0.
REQ-020 Latency: data read in cycle n SHALL appear with write=1 in cycle n+3 absent backpressure; throughput one sample per cycle.
REQ-021 Backpressure: with full[tag3]=1 the pipeline SHALL freeze, no reads issue, and no sample is lost or duplicated; order within a flux preserved.
REQ-022 A stalled head of flux a SHALL block flux b (no bypass); at most three samples in flight.
REQ-023 Tags of pixel and coefficient words are not compared; the output tag is the selected flux index.
REQ-024 No read SHALL be asserted on a flux whose any input is empty; no write SHALL be asserted on a full flux.

Reset
REQ-025 While rst_n==0 at a rising edge, v1/v2/v3 SHALL clear to 0 and all data/tag registers to 0.
REQ-026 During and in the cycle after reset, write=0; reads SHALL be 0 while rst_n==0.
REQ-027 Reset mid-operation SHALL discard all in-flight samples; none emerge after release.
REQ-028 First issue SHALL be possible in the first cycle with rst_n==1.

Verification
REQ-029 Flux 0, c=(0,0,0,64,0,0,0,0), p3=100 others 0 -> three cycles later write=1, din={0,16'd6400}.
REQ-030 c=(-1,4,-11,40,40,-11,4,-1), p1=p3=p5=p7=255 others 0 -> din field 16'd8160.
REQ-031 c=(-1,4,-10,58,17,-5,1,0), p0=p2=p5=255 others 0 -> din field 16'hF010 (-4080).
REQ-032 Five back-to-back samples on flux 0, full[0]=1 for 6 cycles -> exactly 3 reads then freeze, write=0; on release five writes in input order, none lost.
REQ-033 Flux 0 and 1 both eligible for 4 cycles -> only flux 0 read; flux 1 read first cycle flux 0 becomes empty; output tags match.
REQ-034 rst_n=0 for one cycle with 2 samples in flight -> write=0 thereafter, no outputs until new issue, next output after 3 cycles.
